// File: rtl/ser2par_pkg.sv
// +----------------------------------------------------------------------------+
// | ser2par_pkg : shared widths and slot arithmetic for the serial packer      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package ser2par_pkg;

  localparam int STAT_WORDS_W = 32;
  localparam int STAT_FLUSH_W = 16;

  // Width needed to hold an element count in the range 0..elems.
  function automatic int count_width(input int elems);
    return $clog2(elems + 1);
  endfunction

  function automatic int slot_lo(input int slot, input int in_size, input int out_size,
                                 input bit msb_first);
    return msb_first ? (out_size - (slot + 1) * in_size) : (slot * in_size);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_to_parallel_packer_if.sv
// +----------------------------------------------------------------------------+
// | serial_to_parallel_packer_if : serial-in / word-out stream handshakes      |
// | Revision                     : 1.0                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface serial_to_parallel_packer_if #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 8,
  parameter int CNT_W = 4
) ();

  logic             in_ready;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );

endinterface

`default_nettype wire

// File: rtl/stream_out_reg.sv
// +----------------------------------------------------------------------------+
// | stream_out_reg : one-entry valid/ready register with data/count/last       |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_out_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              load_last,
  output logic              can_load,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              last
);

  // Loading while the held word is being taken keeps one word per cycle.
  assign can_load = !valid || ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
      last  <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      count <= load_count;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_to_parallel_packer.sv
// +----------------------------------------------------------------------------+
// | serial_to_parallel_packer : packs INPUT_SIZE beats into OUTPUT_SIZE words  |
// | Optional macro SER2PAR_STATS_EN adds stat_words / stat_flush counters.     |
// | Revision                  : 1.0                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_to_parallel_packer
  import ser2par_pkg::*;
#(
  parameter int INPUT_SIZE  = 1,
  parameter int OUTPUT_SIZE = 8,
  parameter int MSB_FIRST   = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  serial_to_parallel_packer_if.slave bus
`ifdef SER2PAR_STATS_EN
  ,
  output logic [STAT_WORDS_W-1:0] stat_words,
  output logic [STAT_FLUSH_W-1:0] stat_flush
`endif
);

  localparam int ELEMS = OUTPUT_SIZE / INPUT_SIZE;
  localparam int CW    = count_width(ELEMS);
  localparam logic [CW-1:0] FULL = CW'(ELEMS);

  if ((OUTPUT_SIZE % INPUT_SIZE) != 0 || OUTPUT_SIZE < INPUT_SIZE) begin : g_size_check
    $error("OUTPUT_SIZE must be a non-zero multiple of INPUT_SIZE");
  end

  logic [OUTPUT_SIZE-1:0] acc_data;
  logic [CW-1:0]          acc_cnt;
  logic                   acc_last;
  logic                   acc_done;

  logic [OUTPUT_SIZE-1:0] nxt_data;
  logic [CW-1:0]          nxt_cnt;
  logic                   nxt_last;
  logic                   nxt_done;
  logic [OUTPUT_SIZE-1:0] base_data;
  logic [CW-1:0]          base_cnt;

  logic                   can_load;
  logic                   xfer;
  logic                   accept;
  logic                   out_valid;
  logic [OUTPUT_SIZE-1:0] out_data;
  logic [CW-1:0]          out_count;
  logic                   out_last;

  assign xfer         = acc_done && can_load;
  assign bus.in_ready = rstn && !clear && (!acc_done || xfer);
  assign accept       = bus.in_valid && bus.in_ready;

  // A word leaving this cycle frees the accumulator, so a new beat lands in slot 0 of a zeroed word.
  always_comb begin
    base_cnt  = xfer ? '0 : acc_cnt;
    base_data = xfer ? '0 : acc_data;
    nxt_data  = base_data;
    nxt_cnt   = base_cnt;
    nxt_last  = xfer ? 1'b0 : acc_last;
    nxt_done  = xfer ? 1'b0 : acc_done;
    if (accept) begin
      for (int s = 0; s < ELEMS; s++) begin
        if (base_cnt == CW'(s)) begin
          nxt_data[slot_lo(s, INPUT_SIZE, OUTPUT_SIZE, MSB_FIRST != 0) +: INPUT_SIZE] = bus.in_data;
        end
      end
      nxt_cnt  = base_cnt + CW'(1);
      nxt_last = bus.in_last;
      nxt_done = bus.in_last || (nxt_cnt == FULL);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_data <= '0;
      acc_cnt  <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
    end else if (clear) begin
      acc_data <= '0;
      acc_cnt  <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
    end else begin
      acc_data <= nxt_data;
      acc_cnt  <= nxt_cnt;
      acc_last <= nxt_last;
      acc_done <= nxt_done;
    end
  end

  stream_out_reg #(
    .DATA_W (OUTPUT_SIZE),
    .CNT_W  (CW)
  ) u_out_reg (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .load       (xfer),
    .load_data  (acc_data),
    .load_count (acc_cnt),
    .load_last  (acc_last),
    .can_load   (can_load),
    .ready      (bus.out_ready),
    .valid      (out_valid),
    .data       (out_data),
    .count      (out_count),
    .last       (out_last)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_count = out_count;
  assign bus.out_last  = out_last;

`ifdef SER2PAR_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_words <= '0;
      stat_flush <= '0;
    end else if (clear) begin
      stat_words <= '0;
      stat_flush <= '0;
    end else if (out_valid && bus.out_ready) begin
      stat_words <= stat_words + STAT_WORDS_W'(1);
      if (out_last && (out_count != FULL) && (stat_flush != '1)) begin
        stat_flush <= stat_flush + STAT_FLUSH_W'(1);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_to_parallel_packer.sv
// +----------------------------------------------------------------------------+
// | tb_serial_to_parallel_packer : directed + randomized bench, three configs  |
// | Revision                     : 1.0                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_to_parallel_packer;
  import ser2par_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic clear;
  always #5 clk = ~clk;

  // a: 1->8 MSB-first, b: 1->8 LSB-first (mirrors a's inputs), c: 4->16 MSB-first
  serial_to_parallel_packer_if #(.IN_W(1), .OUT_W(8),  .CNT_W(4)) ifa ();
  serial_to_parallel_packer_if #(.IN_W(1), .OUT_W(8),  .CNT_W(4)) ifb ();
  serial_to_parallel_packer_if #(.IN_W(4), .OUT_W(16), .CNT_W(3)) ifc ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_data   = ifa.in_data;
  assign ifb.in_last   = ifa.in_last;
  assign ifb.out_ready = ifa.out_ready;

`ifdef SER2PAR_STATS_EN
  logic [STAT_WORDS_W-1:0] sw_a, sw_b, sw_c;
  logic [STAT_FLUSH_W-1:0] sf_a, sf_b, sf_c;
`endif

  serial_to_parallel_packer #(.INPUT_SIZE(1), .OUTPUT_SIZE(8), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .clear(clear), .bus(ifa)
`ifdef SER2PAR_STATS_EN
    , .stat_words(sw_a), .stat_flush(sf_a)
`endif
  );
  serial_to_parallel_packer #(.INPUT_SIZE(1), .OUTPUT_SIZE(8), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .clear(clear), .bus(ifb)
`ifdef SER2PAR_STATS_EN
    , .stat_words(sw_b), .stat_flush(sf_b)
`endif
  );
  serial_to_parallel_packer #(.INPUT_SIZE(4), .OUTPUT_SIZE(16), .MSB_FIRST(1)) u_dut_c (
    .clk(clk), .rstn(rstn), .clear(clear), .bus(ifc)
`ifdef SER2PAR_STATS_EN
    , .stat_words(sw_c), .stat_flush(sf_c)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: words are built by shifting/or-ing elements, then compared in order per DUT.
  typedef struct {
    int          k;
    logic [15:0] d;
    int          c;
    bit          l;
  } exp_t;

  int          p_in  [3] = '{1, 1, 4};
  int          p_out [3] = '{8, 8, 16};
  bit          p_msb [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] mw    [3];
  int          mn    [3];
  bit          hold  [3];
  logic [15:0] hold_d[3];
  int          hs_cnt[3] = '{0, 0, 0};
  exp_t        expq[$];
  int          last_hs0 = -1;
  int          max_gap  = 0;
  bit          t4_on    = 1'b0;
  int          t4_stalls = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mw[k]   = '0;
      mn[k]   = 0;
      hold[k] = 1'b0;
    end
    expq.delete();
  endtask

  task automatic model_accept(input int k, input logic [15:0] d, input bit l);
    int   e;
    exp_t x;
    e = p_out[k] / p_in[k];
    if (p_msb[k]) mw[k] = (mw[k] << p_in[k]) | d;
    else          mw[k] = mw[k] | (d << (mn[k] * p_in[k]));
    mn[k]++;
    if (mn[k] == e || l) begin
      x.k = k;
      x.d = p_msb[k] ? (mw[k] << ((e - mn[k]) * p_in[k])) : mw[k];
      x.c = mn[k];
      x.l = l;
      expq.push_back(x);
      mw[k] = '0;
      mn[k] = 0;
    end
  endtask

  task automatic observe(input int k, input logic iv, input logic ir, input logic [15:0] id,
                         input logic il, input logic ov, input logic orr, input logic [15:0] od,
                         input logic [31:0] oc, input logic ol);
    int idx;
    if (iv && ir) model_accept(k, id, il);
    if (hold[k]) begin
      check($sformatf("hold_valid_%0d", k), 32'(ov), 32'd1);
      check($sformatf("hold_data_%0d", k), 32'(od), 32'(hold_d[k]));
    end
    hold[k]   = ov && !orr;
    hold_d[k] = od;
    if (ov && orr) begin
      idx = -1;
      foreach (expq[i]) if (idx < 0 && expq[i].k == k) idx = i;
      check($sformatf("word_expected_%0d", k), 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        check($sformatf("sb_data_%0d", k), 32'(od), 32'(expq[idx].d));
        check($sformatf("sb_count_%0d", k), oc, 32'(expq[idx].c));
        check($sformatf("sb_last_%0d", k), 32'(ol), 32'(expq[idx].l));
        expq.delete(idx);
      end
      hs_cnt[k]++;
      if (k == 0) begin
        if (last_hs0 >= 0 && (cyc - last_hs0) > max_gap) max_gap = cyc - last_hs0;
        last_hs0 = cyc;
      end
    end
  endtask

  // Inputs change 1 time unit after posedge, so negedge sees exactly what the next edge will take.
  always @(negedge clk) begin
    cyc++;
    if (!rstn || clear) begin
      model_reset();
    end else begin
      if (t4_on && !ifa.in_ready) t4_stalls++;
      observe(0, ifa.in_valid, ifa.in_ready, 16'(ifa.in_data), ifa.in_last, ifa.out_valid,
              ifa.out_ready, 16'(ifa.out_data), 32'(ifa.out_count), ifa.out_last);
      observe(1, ifb.in_valid, ifb.in_ready, 16'(ifb.in_data), ifb.in_last, ifb.out_valid,
              ifb.out_ready, 16'(ifb.out_data), 32'(ifb.out_count), ifb.out_last);
      observe(2, ifc.in_valid, ifc.in_ready, 16'(ifc.in_data), ifc.in_last, ifc.out_valid,
              ifc.out_ready, ifc.out_data, 32'(ifc.out_count), ifc.out_last);
    end
  end

  task automatic send_a(input logic d, input bit l);
    bit ok;
    ok = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    ifa.in_last  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = ifa.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    ifa.in_valid = 1'b0;
    ifa.in_last  = 1'b0;
    check("send_a_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_c(input logic [3:0] d, input bit l);
    bit ok;
    ok = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = ifc.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    check("send_c_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_out(input int k);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if ((k == 0) ? ifa.out_valid : ifc.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_out_valid", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int         base;
    int         sent;
    bit         acc;
    bit         done_a;
    bit         done_c;

    rstn = 1'b0;
    clear = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0; ifa.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_last = 1'b0; ifc.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready_a", 32'(ifa.in_ready), 32'd0);
    check("rst_out_valid_a", 32'(ifa.out_valid), 32'd0);
    check("rst_out_data_a", 32'(ifa.out_data), 32'd0);
    check("rst_out_count_a", 32'(ifa.out_count), 32'd0);
    check("rst_out_last_a", 32'(ifa.out_last), 32'd0);
    check("rst_in_ready_c", 32'(ifc.in_ready), 32'd0);
    check("rst_out_valid_c", 32'(ifc.out_valid), 32'd0);
`ifdef SER2PAR_STATS_EN
    check("rst_stat_words", sw_a, 32'd0);
    check("rst_stat_flush", 32'(sf_a), 32'd0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready_a", 32'(ifa.in_ready), 32'd1);
    @(posedge clk); #1;

    // Bits 1,0,1,1,0,0,1,0: MSB-first -> B2, LSB-first -> 4D, valid one edge after the 8th beat
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) send_a(pat[i], 1'b0);
    @(negedge clk);
    check("lat_not_early_a", 32'(ifa.out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_a", 32'(ifa.out_valid), 32'd1);
    check("msb_word", 32'(ifa.out_data), 32'hB2);
    check("msb_count", 32'(ifa.out_count), 32'd8);
    check("msb_last", 32'(ifa.out_last), 32'd0);
    check("lat_valid_b", 32'(ifb.out_valid), 32'd1);
    check("lsb_word", 32'(ifb.out_data), 32'h4D);
    check("lsb_count", 32'(ifb.out_count), 32'd8);
    @(posedge clk); #1;

    // Nibbles A,B,C(last) then 1,2,3,4
    send_c(4'hA, 1'b0); send_c(4'hB, 1'b0); send_c(4'hC, 1'b1);
    wait_out(2);
    check("flush_word_c", 32'(ifc.out_data), 32'hABC0);
    check("flush_count_c", 32'(ifc.out_count), 32'd3);
    check("flush_last_c", 32'(ifc.out_last), 32'd1);
    @(posedge clk); #1;
    send_c(4'h1, 1'b0); send_c(4'h2, 1'b0); send_c(4'h3, 1'b0); send_c(4'h4, 1'b0);
    wait_out(2);
    check("full_word_c", 32'(ifc.out_data), 32'h1234);
    check("full_count_c", 32'(ifc.out_count), 32'd4);
    check("full_last_c", 32'(ifc.out_last), 32'd0);
    @(posedge clk); #1;

    // 64 back-to-back beats with out_ready held high
    base = hs_cnt[0];
    last_hs0 = -1;
    max_gap = 0;
    t4_stalls = 0;
    t4_on = 1'b1;
    for (int i = 0; i < 64; i++) send_a(1'($urandom_range(0, 1)), 1'b0);
    t4_on = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stream_no_stall", 32'(t4_stalls), 32'd0);
    check("stream_words", 32'(hs_cnt[0] - base), 32'd8);
    check("stream_gap_le8", 32'(max_gap <= 8), 32'd1);

    // Backpressure: 30 cycles without out_ready, 24 beats offered
    base = hs_cnt[0];
    sent = 0;
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_data = 1'($urandom_range(0, 1));
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); acc = ifa.in_valid && ifa.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 24) ifa.in_data = 1'($urandom_range(0, 1));
        else ifa.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("bp_accepted", 32'(sent), 32'd16);
    check("bp_in_ready_low", 32'(ifa.in_ready), 32'd0);
    check("bp_out_valid", 32'(ifa.out_valid), 32'd1);
    @(posedge clk); #1;
    ifa.out_ready = 1'b1;
    for (int c = 0; c < 100 && sent < 24; c++) begin
      @(negedge clk); acc = ifa.in_valid && ifa.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 24) ifa.in_data = 1'($urandom_range(0, 1));
        else ifa.in_valid = 1'b0;
      end
    end
    ifa.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("bp_total_sent", 32'(sent), 32'd24);
    check("bp_words", 32'(hs_cnt[0] - base), 32'd3);
    check("bp_sb_empty", 32'(expq.size()), 32'd0);

    // Reset mid-word: no stale bits
    send_a(1'b1, 1'b0); send_a(1'b0, 1'b0); send_a(1'b1, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(ifa.in_ready), 32'd0);
    check("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("midrst_out_data", 32'(ifa.out_data), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
`ifdef SER2PAR_STATS_EN
    @(negedge clk);
    check("midrst_stat_words0", sw_a, 32'd0);
    check("midrst_stat_flush0", 32'(sf_a), 32'd0);
    @(posedge clk); #1;
`endif
    for (int i = 0; i < 8; i++) send_a(1'b1, 1'b0);
    wait_out(0);
    check("midrst_word", 32'(ifa.out_data), 32'hFF);
    check("midrst_count", 32'(ifa.out_count), 32'd8);
    @(posedge clk); #1;
`ifdef SER2PAR_STATS_EN
    @(negedge clk);
    check("midrst_stat_words1", sw_a, 32'd1);
    @(posedge clk); #1;
`endif

    // Clear mid-word
    send_a(1'b0, 1'b0); send_a(1'b1, 1'b0); send_a(1'b0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 32'(ifa.in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clr_out_valid", 32'(ifa.out_valid), 32'd0);
`ifdef SER2PAR_STATS_EN
    check("clr_stat_words0", sw_a, 32'd0);
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_a(1'b1, 1'b0);
    wait_out(0);
    check("clr_word", 32'(ifa.out_data), 32'hFF);
    check("clr_count", 32'(ifa.out_count), 32'd8);
    @(posedge clk); #1;

    // in_last on 3rd and on 1st element
    send_a(1'b1, 1'b0); send_a(1'b0, 1'b0); send_a(1'b1, 1'b1);
    wait_out(0);
    check("last3_word_a", 32'(ifa.out_data), 32'hA0);
    check("last3_word_b", 32'(ifb.out_data), 32'h05);
    check("last3_count", 32'(ifa.out_count), 32'd3);
    check("last3_last", 32'(ifa.out_last), 32'd1);
    @(posedge clk); #1;
    send_a(1'b1, 1'b1);
    wait_out(0);
    check("last1_word_a", 32'(ifa.out_data), 32'h80);
    check("last1_word_b", 32'(ifb.out_data), 32'h01);
    check("last1_count", 32'(ifa.out_count), 32'd1);
    @(posedge clk); #1;
`ifdef SER2PAR_STATS_EN
    @(negedge clk);
    check("stat_words_3", sw_a, 32'd3);
    check("stat_flush_2", 32'(sf_a), 32'd2);
    @(posedge clk); #1;
`endif

    // Randomized traffic with random backpressure, checked by the scoreboard
    done_a = 1'b0;
    done_c = 1'b0;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_a(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end
        done_a = 1'b1;
      end
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_c(4'($urandom), $urandom_range(0, 5) == 0);
        end
        done_c = 1'b1;
      end
      begin
        while (!(done_a && done_c)) begin
          @(posedge clk); #1;
          ifa.out_ready = 1'($urandom_range(0, 1));
          ifc.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ifa.out_ready = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("random_sb_drained", 32'(expq.size()), 32'd0);
    check("random_a_partial", 32'(mn[0] < 8), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
